// File: rtl/iter_muldiv_unit_if.sv
// iter_muldiv_unit_if
//   Request/result bundle between the EX stage and the iterative mul/div unit.
//   master : EX stage side (drives start/op/src1/src2/annul, reads results)
//   slave  : iter_muldiv_unit side
//   start        request new operation (sampled only while the unit is idle)
//   op           00=MULTU 01=MULT 10=DIVU 11=DIV
//   src1/src2    multiplicand/dividend, multiplier/divisor
//   annul        flush: abort the operation in flight
//   stallreq     EX stall request
//   busy         unit not idle
//   done         one-cycle pulse, hi/lo updated this cycle
//   hi/lo        MUL: product high/low halves; DIV: remainder/quotient
//   div_by_zero  qualifies done for a divide with a zero divisor
interface iter_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             annul;
  logic             stallreq;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, src1, src2, annul,
    input  stallreq, busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, src1, src2, annul,
    output stallreq, busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit
//   Iterative multiply (shift-add) / divide (restoring) unit for the EX stage,
//   one iteration per clock. Operands are reduced to magnitudes at start and the
//   sign is fixed up when the result is written to hi/lo.
//   Ports: clk, resetn (synchronous, active low), bus (iter_muldiv_unit_if.slave).
//   Build option: MULDIV_EARLY_OUT_EN - trivial multiplies (a zero operand) and
//   divides with |dividend| < |divisor| finish in one cycle instead of WIDTH+1.
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | WIDTH iterations, cnt_q = 0..WIDTH-1
//   DONE  | one cycle, done pulse, hi/lo already hold the result
module iter_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               resetn,
  iter_muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;         // negate product / quotient
  logic               rem_neg_q, rem_neg_d; // remainder follows dividend sign
  logic [2*WIDTH-1:0] a_q, a_d;             // MUL: shifted multiplicand; DIV: divisor in low half
  logic [2*WIDTH-1:0] acc_q, acc_d;         // MUL: product; DIV: partial remainder in low half
  logic [WIDTH-1:0]   b_q, b_d;             // MUL: multiplier; DIV: dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic               early;
  logic [2*WIDTH-1:0] mul_acc, prod_fix;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic               trial_ok;
  logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

  assign mag1 = (bus.op[0] && bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
  assign mag2 = (bus.op[0] && bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = bus.op[1] ? ((bus.src2 != '0) && (mag1 < mag2))
                           : ((bus.src1 == '0) || (bus.src2 == '0));
`else
  assign early = 1'b0;
`endif

  assign mul_acc  = acc_q + (b_q[0] ? a_q : '0);
  assign prod_fix = neg_q ? -mul_acc : mul_acc;

  // Remainder is always below the divisor, so it fits in WIDTH bits; the extra
  // top bit of the trial difference is the borrow that selects restore.
  assign rem_sh   = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, a_q[WIDTH-1:0]};
  assign trial_ok = ~trial[WIDTH+1];
  assign rem_nx   = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx   = {b_q[WIDTH-2:0], trial_ok};
  assign quo_fix  = neg_q ? -quo_nx : quo_nx;
  assign rem_fix  = rem_neg_q ? -rem_nx : rem_nx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    a_d       = a_q;
    acc_d     = acc_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.annul) begin
          is_div_d  = bus.op[1];
          neg_d     = bus.op[0] & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
          rem_neg_d = bus.op[0] & bus.src1[WIDTH-1];
          cnt_d     = '0;
          acc_d     = '0;
          a_d       = {{WIDTH{1'b0}}, (bus.op[1] ? mag2 : mag1)};
          b_d       = bus.op[1] ? mag1 : mag2;
          dbz_d     = 1'b0;
          if (bus.op[1] && (bus.src2 == '0)) begin
            state_d = S_DONE;
            hi_d    = bus.src1;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else if (early) begin
            state_d = S_DONE;
            hi_d    = bus.op[1] ? bus.src1 : '0;
            lo_d    = '0;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.annul) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (is_div_q) begin
            acc_d = {{WIDTH{1'b0}}, rem_nx};
            b_d   = quo_nx;
          end else begin
            acc_d = mul_acc;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_q       <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  // annul drops stallreq and done in the same cycle so EX can flush immediately.
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.stallreq    = ~bus.annul & (((state_q == S_IDLE) & bus.start) | (state_q == S_CALC));
  assign bus.done        = (state_q == S_DONE) & ~bus.annul;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = bus.done & dbz_q;
endmodule

// File: tb/tb_iter_muldiv_unit.sv
module tb_iter_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  iter_muldiv_unit_if #(.WIDTH(W)) bus ();
  iter_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic         chk_en = 1'b0;
  logic         exp_busy, exp_stall, exp_done, exp_dbz;
  logic [W-1:0] exp_hi, exp_lo;

  int           start_cyc, done_cyc, stall_cnt;
  logic         done_seen;
  logic [W-1:0] seen_hi, seen_lo;
  logic         seen_dbz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Single per-cycle compare against the bench's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 64'(bus.busy), 64'(exp_busy));
      cmp("stallreq", 64'(bus.stallreq), 64'(exp_stall));
      cmp("done", 64'(bus.done), 64'(exp_done));
      cmp("div_by_zero", 64'(bus.div_by_zero), 64'(exp_dbz));
      cmp("hi", 64'(bus.hi), 64'(exp_hi));
      cmp("lo", 64'(bus.lo), 64'(exp_lo));
      if (bus.stallreq) stall_cnt++;
      if (bus.done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        seen_hi   = bus.hi;
        seen_lo   = bus.lo;
        seen_dbz  = bus.div_by_zero;
      end
    end
  end

  // Reference: results from plain 64-bit arithmetic, latency from the op class.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic dbz, output int lat);
    longint sa, sb, ua, ub, ma, mb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ma = op[0] ? ((sa < 0) ? -sa : sa) : ua;
    mb = op[0] ? ((sb < 0) ? -sb : sb) : ub;
    dbz = 1'b0;
    lat = W + 1;
    if (!op[1]) begin
      p  = op[0] ? 64'(sa * sb) : 64'(ua * ub);
      hi = p[63:32];
      lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      if (a == '0 || b == '0) lat = 1;
`endif
    end else if (b == '0) begin
      hi  = a;
      lo  = '1;
      dbz = 1'b1;
      lat = 1;
    end else begin
      if (op[0]) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      lo = q[31:0];
      hi = r[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`else
      if (ma < mb) lat = W + 1;
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.start = 1'b0;
    bus.annul = 1'b0;
    exp_busy  = 1'b0;
    exp_stall = 1'b0;
    exp_done  = 1'b0;
    exp_dbz   = 1'b0;
  endtask

  // Issues one operation from IDLE; annul_at = k asserts annul in the k-th
  // cycle after start (CALC cycle k-1). Leaves the bench at the following IDLE.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int annul_at);
    logic [W-1:0] mh, ml;
    logic md;
    int lat;
    model(op, a, b, mh, ml, md, lat);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src1  = a;
    bus.src2  = b;
    bus.annul = 1'b0;
    exp_busy  = 1'b0;
    exp_stall = 1'b1;
    exp_done  = 1'b0;
    exp_dbz   = 1'b0;
    start_cyc = cyc;
    stall_cnt = 0;
    done_seen = 1'b0;
    step();
    for (int k = 1; k <= lat; k++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.op    = 2'($urandom);
      bus.src1  = $urandom;
      bus.src2  = $urandom;
      exp_busy  = 1'b1;
      if (k == annul_at && k < lat) begin
        bus.annul = 1'b1;
        exp_stall = 1'b0;
        step();
        break;
      end
      if (k == lat) begin
        exp_stall = 1'b0;
        exp_done  = 1'b1;
        exp_dbz   = md;
        exp_hi    = mh;
        exp_lo    = ml;
      end else begin
        exp_stall = 1'b1;
      end
      step();
    end
    go_idle();
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return W'($urandom_range(0, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src1  = '0;
    bus.src2  = '0;
    bus.annul = 1'b0;
    exp_hi    = '0;
    exp_lo    = '0;
    go_idle();
    step();
    chk_en = 1'b1;
    step();
    resetn = 1'b1;
    step();

    // MULT -3 * 7
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
    cmp("mult_hi", 64'(seen_hi), 64'hFFFF_FFFF);
    cmp("mult_lo", 64'(seen_lo), 64'hFFFF_FFEB);
    cmp("mult_latency", 64'(done_cyc - start_cyc), 64'd33);
    cmp("mult_stall_cycles", 64'(stall_cnt), 64'd33);

    // DIV -7 / 2, back-to-back DIVU
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    cmp("div_neg_lo", 64'(seen_lo), 64'hFFFF_FFFD);
    cmp("div_neg_hi", 64'(seen_hi), 64'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h10, 0);
    cmp("divu_lo", 64'(seen_lo), 64'h0FFF_FFFF);
    cmp("divu_hi", 64'(seen_hi), 64'hF);

    // Divide by zero
    run_op(2'b10, 32'h1234, 32'd0, 0);
    cmp("dbz_flag", 64'(seen_dbz), 64'd1);
    cmp("dbz_lo", 64'(seen_lo), 64'hFFFF_FFFF);
    cmp("dbz_hi", 64'(seen_hi), 64'h1234);
    cmp("dbz_latency", 64'(done_cyc - start_cyc), 64'd1);

    // MIN / -1
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    cmp("min_div_lo", 64'(seen_lo), 64'h8000_0000);
    cmp("min_div_hi", 64'(seen_hi), 64'h0);
    cmp("min_div_dbz", 64'(seen_dbz), 64'd0);

    // MULTU 5*6 annulled at CALC cycle 10, then a clean rerun
    run_op(2'b00, 32'd5, 32'd6, 11);
    step();
    cmp("annul_no_done", 64'(done_seen), 64'd0);
    run_op(2'b00, 32'd5, 32'd6, 0);
    cmp("rerun_lo", 64'(seen_lo), 64'd30);
    cmp("rerun_hi", 64'(seen_hi), 64'd0);

    // annul together with start in IDLE: nothing starts
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.op    = 2'b01;
    bus.src1  = 32'd3;
    bus.src2  = 32'd4;
    exp_stall = 1'b0;
    step();
    go_idle();
    step();

    // Synchronous reset in the middle of a divide
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.src1  = 32'h0123_4567;
    bus.src2  = 32'h345;
    exp_stall = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_busy  = 1'b1;
      exp_stall = 1'b1;
      step();
    end
    resetn = 1'b0;
    step();
    resetn    = 1'b1;
    exp_busy  = 1'b0;
    exp_stall = 1'b0;
    exp_hi    = '0;
    exp_lo    = '0;
    step();

    // MULT 0 * 9
    run_op(2'b01, 32'd0, 32'd9, 0);
    cmp("mul_zero_hi", 64'(seen_hi), 64'd0);
    cmp("mul_zero_lo", 64'(seen_lo), 64'd0);
`ifdef MULDIV_EARLY_OUT_EN
    cmp("mul_zero_latency", 64'(done_cyc - start_cyc), 64'd1);
`else
    cmp("mul_zero_latency", 64'(done_cyc - start_cyc), 64'd33);
`endif

    // Randomized operations with occasional annul and idle gaps
    for (int n = 0; n < 200; n++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      int           ak;
      rop = 2'($urandom);
      ra  = rnd_operand();
      rb  = rnd_operand();
      ak  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, W) : 0;
      run_op(rop, ra, rb, ak);
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
